// File: rtl/axim_pkg.sv
// Shared types and helpers for the AXI master address path.
package axim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } burst_gen_state_t;

  localparam int unsigned LP_AXI_4K = 4096;

  // Beats that fit between an (aligned) address and the next 4 KB boundary.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr,
                                              input int unsigned dw_bytes);
    int unsigned room;
    room = LP_AXI_4K - 32'(addr);
    return 13'(room / dw_bytes);
  endfunction

endpackage

// File: rtl/axim_outstanding_cnt.sv
// Up/down counter of issued-but-uncompleted bursts; saturates at 0 and C_MAX.
module axim_outstanding_cnt #(
  parameter int unsigned C_MAX   = 16,
  parameter int unsigned C_CNT_W = $clog2(C_MAX + 1)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_inc,
  input  logic               i_dec,
  output logic [C_CNT_W-1:0] o_count,
  output logic               o_full,
  output logic               o_empty
);

  logic [C_CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_count <= r_count + C_CNT_W'(1);
    end else if (i_dec && !i_inc && (r_count != '0)) begin
      r_count <= r_count - C_CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == C_CNT_W'(C_MAX));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/axim_burst_gen.sv
// AXI4 AR/AW burst command generator: 4 KB / max-length splitting, outstanding limit.
// Optional strided single-beat mode under `AXIM_BURST_GEN_STRIDE_EN.
module axim_burst_gen
  import axim_pkg::*;
#(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
  parameter int unsigned C_MAX_BURST_LEN    = 256,
  parameter int unsigned C_MAX_OUTSTANDING  = 16
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   ctrl_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]          ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0]           ctrl_xfer_size,
`ifdef AXIM_BURST_GEN_STRIDE_EN
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]          ctrl_stride,
  input  logic                                   ctrl_strided,
`endif
  output logic                                   ctrl_busy,
  output logic                                   ctrl_done,
  output logic                                   m_axi_axvalid,
  input  logic                                   m_axi_axready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]          m_axi_axaddr,
  output logic [7:0]                             m_axi_axlen,
  input  logic                                   resp_valid,
  output logic [$clog2(C_MAX_OUTSTANDING+1)-1:0] outstanding
);

  localparam int unsigned DW_BYTES  = C_M_AXI_DATA_WIDTH / 8;
  localparam int unsigned LP_LOG_DW = $clog2(DW_BYTES);
  localparam int unsigned LP_OUT_W  = $clog2(C_MAX_OUTSTANDING + 1);
  localparam int unsigned LP_LEN_W  = $clog2(C_MAX_BURST_LEN + 1);
  localparam int unsigned LP_CMP_W  = (C_XFER_SIZE_WIDTH > 13) ? C_XFER_SIZE_WIDTH : 13;
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] LP_ALIGN_MASK =
    ~C_M_AXI_ADDR_WIDTH'(DW_BYTES - 1);

  burst_gen_state_t r_state, w_next;

  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [C_XFER_SIZE_WIDTH-1:0]  r_beats_rem;
  logic [LP_LEN_W-1:0]           r_len;
  logic [7:0]                    r_axlen;

  logic                          w_load, w_calc, w_hs, w_full, w_empty;
  logic [C_XFER_SIZE_WIDTH-1:0]  w_beats_init, w_beats_after;
  logic [LP_CMP_W-1:0]           w_cap;
  logic [LP_LEN_W-1:0]           w_len;
  logic [C_M_AXI_ADDR_WIDTH-1:0] w_addr_step;

`ifdef AXIM_BURST_GEN_STRIDE_EN
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_stride;
  logic                          r_strided;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stride  <= '0;
      r_strided <= 1'b0;
    end else if (w_load) begin
      r_stride  <= ctrl_stride;
      r_strided <= ctrl_strided;
    end
  end
`endif

  always_comb begin
    w_beats_init  = (ctrl_xfer_size >> LP_LOG_DW)
                  + C_XFER_SIZE_WIDTH'(|(ctrl_xfer_size & C_XFER_SIZE_WIDTH'(DW_BYTES - 1)));
    w_beats_after = r_beats_rem - C_XFER_SIZE_WIDTH'(r_len);
    w_cap         = LP_CMP_W'(beats_to_4k(r_addr[11:0], DW_BYTES));
    if (w_cap > LP_CMP_W'(C_MAX_BURST_LEN)) w_cap = LP_CMP_W'(C_MAX_BURST_LEN);
    w_len         = (LP_CMP_W'(r_beats_rem) < w_cap) ? LP_LEN_W'(r_beats_rem)
                                                     : LP_LEN_W'(w_cap);
    w_addr_step   = C_M_AXI_ADDR_WIDTH'(r_len) << LP_LOG_DW;
`ifdef AXIM_BURST_GEN_STRIDE_EN
    if (r_strided) begin
      w_len       = LP_LEN_W'(1);
      w_addr_step = r_stride;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Valid needs no hold register: the count can only rise through our own handshake.
  always_comb begin
    w_next        = r_state;
    w_load        = 1'b0;
    w_calc        = 1'b0;
    m_axi_axvalid = 1'b0;
    ctrl_busy     = 1'b0;
    ctrl_done     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (ctrl_start) begin
          w_load = 1'b1;
          w_next = (w_beats_init == '0) ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        ctrl_busy = 1'b1;
        w_calc    = 1'b1;
        w_next    = ST_ISSUE;
      end
      ST_ISSUE: begin
        ctrl_busy     = 1'b1;
        m_axi_axvalid = !w_full;
        if (m_axi_axvalid && m_axi_axready)
          w_next = (w_beats_after == '0) ? ST_DRAIN : ST_CALC;
      end
      ST_DRAIN: begin
        ctrl_busy = 1'b1;
        if (w_empty) w_next = ST_DONE;
      end
      ST_DONE: begin
        ctrl_done = 1'b1;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_hs = m_axi_axvalid & m_axi_axready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr      <= '0;
      r_beats_rem <= '0;
      r_len       <= '0;
      r_axlen     <= '0;
    end else begin
      if (w_load) begin
        r_addr      <= ctrl_addr_offset & LP_ALIGN_MASK;
        r_beats_rem <= w_beats_init;
      end else if (w_hs) begin
        r_addr      <= r_addr + w_addr_step;
        r_beats_rem <= w_beats_after;
      end
      if (w_calc) begin
        r_len   <= w_len;
        r_axlen <= 8'(w_len - LP_LEN_W'(1));
      end
    end
  end

  assign m_axi_axaddr = r_addr;
  assign m_axi_axlen  = r_axlen;

  axim_outstanding_cnt #(
    .C_MAX   (C_MAX_OUTSTANDING),
    .C_CNT_W (LP_OUT_W)
  ) u_outstanding_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (w_hs),
    .i_dec   (resp_valid),
    .o_count (outstanding),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
